btle_bit_upsample: RTL and testbench

Bit-to-sample upsampler for the BTLE GFSK transmit chain, directly upstream of the Gaussian filter. It accepts packet bits over a valid/ready handshake and repeats each bit SAMPLE_PER_SYMBOL times, one sample per `sample_en` strobe. It drives the filter's `bit_upsample` / `bit_upsample_valid` / `bit_upsample_valid_last` inputs. After the last bit it optionally appends a flush tail so the filter's delay line drains before `valid_last`.

---
 rtl/btle_bit_upsample.sv | 183 ++++++++++++++++++
 tb/tb_btle_bit_upsample.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btle_bit_upsample.sv
// Repeats each packet bit SAMPLE_PER_SYMBOL times on sample_en strobes for the GFSK Gaussian filter.
// Optional `BTLE_UPSAMPLE_FLUSH_EN appends FLUSH_SAMPLES copies of the last bit so the filter drains.
module btle_bit_upsample #(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int FLUSH_SAMPLES     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic info_bit,
  input  logic info_bit_valid,
  input  logic info_bit_last,
  output logic info_bit_ready,
  output logic bit_upsample,
  output logic bit_upsample_valid,
  output logic bit_upsample_valid_last,
  output logic underrun,
  output logic busy
);

  localparam int RW = (SAMPLE_PER_SYMBOL > 1) ? $clog2(SAMPLE_PER_SYMBOL) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(SAMPLE_PER_SYMBOL - 1);

`ifdef BTLE_UPSAMPLE_FLUSH_EN
  localparam int FW = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
  } state_t;
`endif

  state_t          r_state;
  logic            r_cur_bit;
  logic            r_cur_last;
  logic [RW-1:0]   r_rep_cnt;
  logic            r_bit;
  logic            r_vld;
  logic            r_vld_last;
  logic            r_underrun;

  state_t          w_state_nxt;
  logic            w_cur_bit_nxt;
  logic            w_cur_last_nxt;
  logic [RW-1:0]   w_rep_cnt_nxt;
  logic            w_bit_nxt;
  logic            w_vld_nxt;
  logic            w_vld_last_nxt;
  logic            w_underrun_nxt;
  logic            w_rep_done;
  logic            w_ready;

`ifdef BTLE_UPSAMPLE_FLUSH_EN
  logic [FW-1:0]   r_flush_cnt;
  logic [FW-1:0]   w_flush_cnt_nxt;
`endif

  assign w_rep_done = (r_rep_cnt == REP_LAST);

  // In RUN the next bit is only taken on the strobe that emits the final repetition, so bits abut.
  assign w_ready = (r_state == S_IDLE) ||
                   ((r_state == S_RUN) && sample_en && w_rep_done && !r_cur_last);

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_bit_nxt   = r_cur_bit;
    w_cur_last_nxt  = r_cur_last;
    w_rep_cnt_nxt   = r_rep_cnt;
    w_bit_nxt       = r_bit;
    w_vld_nxt       = 1'b0;
    w_vld_last_nxt  = 1'b0;
    w_underrun_nxt  = 1'b0;
`ifdef BTLE_UPSAMPLE_FLUSH_EN
    w_flush_cnt_nxt = r_flush_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (info_bit_valid) begin
          w_cur_bit_nxt  = info_bit;
          w_cur_last_nxt = info_bit_last;
          w_rep_cnt_nxt  = '0;
          w_state_nxt    = S_RUN;
        end
      end

      S_RUN: begin
        if (sample_en) begin
          w_bit_nxt = r_cur_bit;
          w_vld_nxt = 1'b1;
          if (!w_rep_done) begin
            w_rep_cnt_nxt = r_rep_cnt + 1'b1;
          end else if (r_cur_last) begin
`ifdef BTLE_UPSAMPLE_FLUSH_EN
            w_flush_cnt_nxt = '0;
            w_state_nxt     = S_FLUSH;
`else
            w_vld_last_nxt  = 1'b1;
            w_state_nxt     = S_IDLE;
`endif
          end else if (info_bit_valid) begin
            w_cur_bit_nxt  = info_bit;
            w_cur_last_nxt = info_bit_last;
            w_rep_cnt_nxt  = '0;
          end else begin
            // Starved mid-packet: the final repetition still goes out alongside the pulse.
            w_underrun_nxt = 1'b1;
            w_rep_cnt_nxt  = '0;
            w_state_nxt    = S_IDLE;
          end
        end
      end

`ifdef BTLE_UPSAMPLE_FLUSH_EN
      S_FLUSH: begin
        if (sample_en) begin
          w_bit_nxt = r_cur_bit;
          w_vld_nxt = 1'b1;
          if (r_flush_cnt == FLUSH_LAST) begin
            w_vld_last_nxt  = 1'b1;
            w_flush_cnt_nxt = '0;
            w_rep_cnt_nxt   = '0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt + 1'b1;
          end
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_bit   <= 1'b0;
      r_cur_last  <= 1'b0;
      r_rep_cnt   <= '0;
      r_bit       <= 1'b0;
      r_vld       <= 1'b0;
      r_vld_last  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_bit   <= w_cur_bit_nxt;
      r_cur_last  <= w_cur_last_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_vld       <= w_vld_nxt;
      r_vld_last  <= w_vld_last_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

`ifdef BTLE_UPSAMPLE_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else begin
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end
`endif

  assign info_bit_ready          = w_ready;
  assign bit_upsample            = r_bit;
  assign bit_upsample_valid      = r_vld;
  assign bit_upsample_valid_last = r_vld_last;
  assign underrun                = r_underrun;
  assign busy                    = (r_state != S_IDLE);

endmodule

// File: tb/tb_btle_bit_upsample.sv
// Directed bench for btle_bit_upsample: packet shapes, strobe spacing, underrun, mid-packet reset, ready timing.
module tb_btle_bit_upsample;

  localparam int SPS = 8;
  localparam int FLS = 16;
`ifdef BTLE_UPSAMPLE_FLUSH_EN
  localparam int TAIL = FLS;
`else
  localparam int TAIL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_en;
  logic info_bit = 1'b0;
  logic info_bit_valid = 1'b0;
  logic info_bit_last = 1'b0;
  logic info_bit_ready;
  logic bit_upsample;
  logic bit_upsample_valid;
  logic bit_upsample_valid_last;
  logic underrun;
  logic busy;

  btle_bit_upsample #(
    .SAMPLE_PER_SYMBOL(SPS),
    .FLUSH_SAMPLES    (FLS)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .sample_en              (sample_en),
    .info_bit               (info_bit),
    .info_bit_valid         (info_bit_valid),
    .info_bit_last          (info_bit_last),
    .info_bit_ready         (info_bit_ready),
    .bit_upsample           (bit_upsample),
    .bit_upsample_valid     (bit_upsample_valid),
    .bit_upsample_valid_last(bit_upsample_valid_last),
    .underrun               (underrun),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Strobe generator: sample_en high every se_period-th cycle (0 = never).
  int se_period = 0;
  int cyc = 0;
  initial begin
    sample_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      sample_en = (se_period > 0) && ((cyc % se_period) == 0);
    end
  end

  // Output monitor: every accepted sample plus running event counters.
  logic samp_q[$];
  int   last_idx_q[$];
  int   nsamp = 0, nur = 0, ur_at = 0, ur_nov = 0, xfer_cnt = 0;
  int   rdy_run = 0, rdy_viol = 0, dly_viol = 0, last_busy_viol = 0;
  logic prev_se = 1'b0;

  always @(negedge clk) begin
    if (bit_upsample_valid) begin
      if (!prev_se) dly_viol <= dly_viol + 1;
      samp_q.push_back(bit_upsample);
      nsamp <= nsamp + 1;
      if (bit_upsample_valid_last) begin
        last_idx_q.push_back(nsamp + 1);
        if (busy) last_busy_viol <= last_busy_viol + 1;
      end
    end
    if (underrun) begin
      nur   <= nur + 1;
      ur_at <= nsamp + (bit_upsample_valid ? 1 : 0);
      if (!bit_upsample_valid) ur_nov <= ur_nov + 1;
    end
    if (info_bit_ready && info_bit_valid && !rst) xfer_cnt <= xfer_cnt + 1;
    if (busy && info_bit_ready) begin
      rdy_run <= rdy_run + 1;
      if (!sample_en) rdy_viol <= rdy_viol + 1;
    end
    prev_se <= sample_en;
  end

  // Presents bits[0..n-1] in order; last flag on the final bit if end_last. Gives up on reset.
  task automatic push_pkt(input logic [7:0] bits, input int n, input logic end_last);
    int waited;
    bit aborted;
    aborted = 1'b0;
    for (int i = 0; i < n && !aborted; i++) begin
      info_bit       = bits[i];
      info_bit_last  = end_last && (i == n - 1);
      info_bit_valid = 1'b1;
      waited = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        if (info_bit_ready) break;
        waited++;
        if (waited > 1000) begin
          chk("xfer_timeout", 1, 0);
          aborted = 1'b1;
          break;
        end
      end
      if (!aborted) begin
        @(posedge clk);
        #1;
      end
    end
    info_bit_valid = 1'b0;
    info_bit_last  = 1'b0;
  endtask

  task automatic wait_samples(input int target);
    int n;
    n = 0;
    while (nsamp < target) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 2000) begin
        chk("sample_timeout", nsamp, target);
        break;
      end
    end
  endtask

  task automatic wait_last(input int target);
    int n;
    n = 0;
    while (last_idx_q.size() < target) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 2000) begin
        chk("last_timeout", last_idx_q.size(), target);
        break;
      end
    end
  endtask

  // Expected stream: each bit SPS times, then the last bit TAIL times; one valid_last on the final sample.
  task automatic check_pkt(input string tag, input logic [7:0] bits, input int n,
                           input int base, input int lbase);
    int   exp_n, mism;
    logic b;
    exp_n = n * SPS + TAIL;
    chk({tag, "_count"}, nsamp - base, exp_n);
    mism = 0;
    for (int i = 0; i < exp_n; i++) begin
      b = (i < n * SPS) ? bits[i / SPS] : bits[n - 1];
      if (base + i >= samp_q.size()) mism++;
      else if (samp_q[base + i] !== b) mism++;
    end
    chk({tag, "_values"}, mism, 0);
    chk({tag, "_nlast"}, last_idx_q.size() - lbase, 1);
    if (last_idx_q.size() > lbase) chk({tag, "_lastpos"}, last_idx_q[lbase] - base, exp_n);
  endtask

  initial begin
    int base, lbase, ur0, dv0, x0, r0, mism;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bit_upsample_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bit", bit_upsample, 0);
    chk("rst_last", bit_upsample_valid_last, 0);
    chk("rst_underrun", underrun, 0);
    chk("idle_ready", info_bit_ready, 1);

    // Back-to-back 1,0,1(last), strobe every cycle
    @(posedge clk); #1;
    se_period = 1;
    base = nsamp; lbase = last_idx_q.size(); ur0 = nur;
    push_pkt(8'b0000_0101, 3, 1'b1);
    wait_last(lbase + 1);
    repeat (2) @(posedge clk); #1;
    check_pkt("b2b", 8'b0000_0101, 3, base, lbase);
    chk("b2b_underrun", nur - ur0, 0);
    chk("b2b_busy_end", busy, 0);

    // Same packet, strobe every 4th cycle
    se_period = 4;
    base = nsamp; lbase = last_idx_q.size(); ur0 = nur; dv0 = dly_viol;
    push_pkt(8'b0000_0101, 3, 1'b1);
    wait_last(lbase + 1);
    repeat (6) @(posedge clk); #1;
    check_pkt("sparse", 8'b0000_0101, 3, base, lbase);
    chk("sparse_underrun", nur - ur0, 0);
    chk("sparse_delay", dly_viol - dv0, 0);

    // Underrun: bit 1 alone, bit 0 (last) arrives 5 cycles after its 8th sample
    se_period = 1;
    base = nsamp; ur0 = nur;
    push_pkt(8'b0000_0001, 1, 1'b0);
    wait_samples(base + SPS);
    chk("ur_pulse", nur - ur0, 1);
    chk("ur_with_sample", ur_at - base, SPS);
    chk("ur_no_valid", ur_nov, 0);
    chk("ur_busy", busy, 0);
    mism = 0;
    for (int i = 0; i < SPS; i++) if (samp_q[base + i] !== 1'b1) mism++;
    chk("ur_first_values", mism, 0);
    repeat (5) @(posedge clk); #1;
    base = nsamp; lbase = last_idx_q.size();
    push_pkt(8'b0000_0000, 1, 1'b1);
    wait_last(lbase + 1);
    repeat (2) @(posedge clk); #1;
    check_pkt("ur_resume", 8'b0000_0000, 1, base, lbase);

    // Reset after 11 samples of a 3-bit packet
    base = nsamp; lbase = last_idx_q.size();
    fork
      push_pkt(8'b0000_0011, 3, 1'b1);
      begin
        wait_samples(base + 11);
        rst = 1'b1;
        #1;
        chk("mrst_valid", bit_upsample_valid, 0);
        chk("mrst_bit", bit_upsample, 0);
        chk("mrst_last", bit_upsample_valid_last, 0);
        chk("mrst_underrun", underrun, 0);
        chk("mrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("mrst_nlast", last_idx_q.size() - lbase, 0);
    chk("mrst_samples", nsamp - base, 11);
    base = nsamp; lbase = last_idx_q.size();
    push_pkt(8'b0000_0010, 2, 1'b1);
    wait_last(lbase + 1);
    repeat (2) @(posedge clk); #1;
    check_pkt("post_rst", 8'b0000_0010, 2, base, lbase);
    chk("post_rst_busy", busy, 0);

    // Valid held high across a 4-bit packet, strobe every 2nd cycle
    se_period = 2;
    chk("hold_idle_ready", info_bit_ready, 1);
    base = nsamp; lbase = last_idx_q.size(); ur0 = nur; x0 = xfer_cnt; r0 = rdy_run;
    push_pkt(8'b0000_0101, 4, 1'b1);
    wait_last(lbase + 1);
    repeat (4) @(posedge clk); #1;
    check_pkt("hold", 8'b0000_0101, 4, base, lbase);
    chk("hold_xfers", xfer_cnt - x0, 4);
    chk("hold_run_ready", rdy_run - r0, 3);
    chk("hold_underrun", nur - ur0, 0);

    chk("ready_only_on_strobe", rdy_viol, 0);
    chk("valid_after_strobe", dly_viol, 0);
    chk("idle_with_last", last_busy_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
